// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds FSM encoding, forwarding selects and the stage-control bundle.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_en:        1'b0,
        ifid_en:      1'b0,
        ifid_flush:   1'b1,
        idex_en:      1'b0,
        idex_flush:   1'b1,
        exmem_en:     1'b0,
        memwb_bubble: 1'b1
    };

    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_en:        1'b1,
        ifid_en:      1'b1,
        ifid_flush:   1'b0,
        idex_en:      1'b1,
        idex_flush:   1'b0,
        exmem_en:     1'b1,
        memwb_bubble: 1'b0
    };

    // Stage contents are held, so nothing is flushed; only the
    // write-back slot is neutralised to avoid a repeated write.
    localparam pipe_ctrl_t CTRL_FREEZE = '{
        pc_en:        1'b0,
        ifid_en:      1'b0,
        ifid_flush:   1'b0,
        idex_en:      1'b0,
        idex_flush:   1'b0,
        exmem_en:     1'b0,
        memwb_bubble: 1'b1
    };

    localparam pipe_ctrl_t CTRL_BRANCH = '{
        pc_en:        1'b1,
        ifid_en:      1'b1,
        ifid_flush:   1'b1,
        idex_en:      1'b1,
        idex_flush:   1'b1,
        exmem_en:     1'b1,
        memwb_bubble: 1'b0
    };

    localparam pipe_ctrl_t CTRL_JUMP = '{
        pc_en:        1'b1,
        ifid_en:      1'b1,
        ifid_flush:   1'b1,
        idex_en:      1'b1,
        idex_flush:   1'b0,
        exmem_en:     1'b1,
        memwb_bubble: 1'b0
    };

    // PC and IF/ID hold; ID/EX still loads, but loads a bubble.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pc_en:        1'b0,
        ifid_en:      1'b0,
        ifid_flush:   1'b0,
        idex_en:      1'b1,
        idex_flush:   1'b1,
        exmem_en:     1'b1,
        memwb_bubble: 1'b0
    };

    // EX/MEM result is newer than MEM/WB, so it wins a tie.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_we && mem_rd != REG_ZERO && mem_rd == src)
            sel = FWD_MEM;
        else if (wb_we && wb_rd != REG_ZERO && wb_rd == src)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX operand forwarding selects for both ALU operands.
// In: ex_rs/ex_rt, EX/MEM and MEM/WB write info. Out: fwd_a, fwd_b.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_rd,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_rd,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    assign fwd_a = fwd_sel(mem_regwrite, mem_rd,
                           wb_regwrite, wb_rd, ex_rs);

    assign fwd_b = fwd_sel(mem_regwrite, mem_rd,
                           wb_regwrite, wb_rd, ex_rt);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, freezes, forwarding.
// In: stage-register fields, dmem handshake. Out: stage enables/flushes,
// fwd_a/fwd_b, sticky mem_err, saturating stall_cnt.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             jump_id,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken_ex,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST =
        TIMEOUT_W'(TIMEOUT - 1);

    state_e                 state_q;
    state_e                 state_d;
    logic [TIMEOUT_W-1:0]   tmo_q;
    logic                   err_q;
    logic [CNT_W-1:0]       cnt_q;
    pipe_ctrl_t             ctrl;
    logic                   freeze;
    logic                   load_use;
    logic                   sel_frz;
    logic                   sel_br;
    logic                   sel_lu;
    logic                   sel_jmp;
    logic                   enter_wait;
    logic [1:0]             fa_raw;
    logic [1:0]             fb_raw;

    // RegWrite of the EX instruction plays no part in these hazards.
    logic                   unused_ex_regwrite;
    assign unused_ex_regwrite = ex_regwrite;

    fwd_unit u_fwd (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .fwd_a        (fa_raw),
        .fwd_b        (fb_raw)
    );

    // An ack in the same cycle ends the wait without a freeze.
    assign freeze = !dmem_ack &&
                    ((state_q == RUN && dmem_req) ||
                     state_q == WAIT);

    assign load_use = ex_memread && ex_rd != REG_ZERO &&
                      (ex_rd == id_rs ||
                       (id_uses_rt && ex_rd == id_rt));

    // One-hot priority: freeze > branch > load-use > jump.
    assign sel_frz = !reset && freeze;
    assign sel_br  = !reset && !freeze && branch_taken_ex;
    assign sel_lu  = !reset && !freeze && !branch_taken_ex &&
                     load_use;
    assign sel_jmp = !reset && !freeze && !branch_taken_ex &&
                     !load_use && jump_id;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (dmem_req && !dmem_ack) state_d = WAIT;
            WAIT:    if (dmem_ack) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ctrl = CTRL_RUN;
        unique case (1'b1)
            reset:   ctrl = CTRL_RESET;
            sel_frz: ctrl = CTRL_FREEZE;
            sel_br:  ctrl = CTRL_BRANCH;
            sel_lu:  ctrl = CTRL_LOAD_USE;
            sel_jmp: ctrl = CTRL_JUMP;
            default: ctrl = CTRL_RUN;
        endcase
    end

    assign enter_wait = state_q == RUN && state_d == WAIT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Holds at the last value once reached; mem_err records the event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_q <= '0;
        else if (enter_wait)
            tmo_q <= '0;
        else if (state_q == WAIT && tmo_q != TMO_LAST)
            tmo_q <= tmo_q + TIMEOUT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (state_q == WAIT && !dmem_ack &&
                 tmo_q == TMO_LAST)
            err_q <= 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (!ctrl.pc_en && cnt_q != '1)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_en      = ctrl.idex_en;
    assign idex_flush   = ctrl.idex_flush;
    assign exmem_en     = ctrl.exmem_en;
    assign memwb_bubble = ctrl.memwb_bubble;

    assign fwd_a     = reset ? FWD_RF : fa_raw;
    assign fwd_b     = reset ? FWD_RF : fb_raw;
    assign mem_err   = err_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Driver queues expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    localparam int CW = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, bubble}
    localparam logic [6:0] C_RST = 7'b0010101;
    localparam logic [6:0] C_NRM = 7'b1101010;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_JMP = 7'b1111010;
    localparam logic [6:0] C_LU  = 7'b0001110;

    typedef struct {
        string       nm;
        logic [6:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        err;
        logic [CW-1:0] cnt;
    } exp_t;

    bit clk = 1'b0;
    logic reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_uses_rt, jump_id, ex_memread, ex_regwrite;
    logic branch_taken_ex, mem_regwrite, dmem_req, dmem_ack;
    logic wb_regwrite;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, memwb_bubble, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;
    logic [6:0] act_ctl;

    exp_t sb[$];
    exp_t me;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .TIMEOUT_W (8),
        .TIMEOUT   (4),
        .CNT_W     (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .jump_id         (jump_id),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_memread      (ex_memread),
        .ex_regwrite     (ex_regwrite),
        .ex_rd           (ex_rd),
        .branch_taken_ex (branch_taken_ex),
        .mem_regwrite    (mem_regwrite),
        .mem_rd          (mem_rd),
        .dmem_req        (dmem_req),
        .dmem_ack        (dmem_ack),
        .wb_regwrite     (wb_regwrite),
        .wb_rd           (wb_rd),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .memwb_bubble    (memwb_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    assign act_ctl = {pc_en, ifid_en, ifid_flush, idex_en,
                      idex_flush, exmem_en, memwb_bubble};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            checks += 4;
            if (act_ctl !== me.ctl) begin
                errors++;
                $display("FAIL %s ctl got %b want %b",
                         me.nm, act_ctl, me.ctl);
            end
            if ({fwd_a, fwd_b} !== {me.fa, me.fb}) begin
                errors++;
                $display("FAIL %s fwd got %b/%b want %b/%b",
                         me.nm, fwd_a, fwd_b, me.fa, me.fb);
            end
            if (mem_err !== me.err) begin
                errors++;
                $display("FAIL %s mem_err got %b want %b",
                         me.nm, mem_err, me.err);
            end
            if (stall_cnt !== me.cnt) begin
                errors++;
                $display("FAIL %s stall_cnt got %0d want %0d",
                         me.nm, stall_cnt, me.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; jump_id = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0;
        ex_memread = 0; ex_regwrite = 0; branch_taken_ex = 0;
        mem_regwrite = 0; mem_rd = 0;
        dmem_req = 0; dmem_ack = 0;
        wb_regwrite = 0; wb_rd = 0;
    endtask

    task automatic lu(input logic [4:0] rd);
        ex_memread = 1; ex_regwrite = 1; ex_rd = rd; id_rs = rd;
    endtask

    task automatic expect_o(input string nm, input logic [6:0] c,
                            input logic [1:0] fa, input logic [1:0] fb,
                            input logic err, input int cnt);
        exp_t e;
        e.nm = nm; e.ctl = c; e.fa = fa; e.fb = fb;
        e.err = err; e.cnt = CW'(cnt);
        sb.push_back(e);
    endtask

    initial begin
        reset = 1;
        clr();
        mem_regwrite = 1; mem_rd = 7; ex_rs = 7;
        tick(); expect_o("rst0", C_RST, 2'b00, 2'b00, 0, 0);
        tick(); expect_o("rst1", C_RST, 2'b00, 2'b00, 0, 0);
        tick(); reset = 0; clr();
        expect_o("idle", C_NRM, 2'b00, 2'b00, 0, 0);

        tick(); lu(5);
        expect_o("lu_rs", C_LU, 2'b00, 2'b00, 0, 0);
        tick(); clr();
        expect_o("lu_after", C_NRM, 2'b00, 2'b00, 0, 1);
        tick(); ex_memread = 1; ex_rd = 9; id_rt = 9;
        id_uses_rt = 1; id_rs = 3;
        expect_o("lu_rt", C_LU, 2'b00, 2'b00, 0, 1);
        tick(); id_uses_rt = 0;
        expect_o("lu_rt_unused", C_NRM, 2'b00, 2'b00, 0, 2);
        tick(); clr(); ex_memread = 1; ex_rd = 0; id_rs = 0;
        expect_o("lu_r0", C_NRM, 2'b00, 2'b00, 0, 2);

        tick(); clr();
        mem_regwrite = 1; wb_regwrite = 1;
        mem_rd = 7; wb_rd = 7; ex_rs = 7; ex_rt = 3;
        expect_o("fwd_mem_wins", C_NRM, 2'b10, 2'b00, 0, 2);
        tick(); mem_regwrite = 0;
        expect_o("fwd_wb", C_NRM, 2'b01, 2'b00, 0, 2);
        tick(); mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0;
        expect_o("fwd_r0", C_NRM, 2'b00, 2'b00, 0, 2);
        tick(); ex_rt = 12; mem_rd = 12; wb_rd = 12;
        expect_o("fwdb_mem", C_NRM, 2'b00, 2'b10, 0, 2);
        tick(); mem_rd = 4;
        expect_o("fwdb_wb", C_NRM, 2'b00, 2'b01, 0, 2);

        tick(); clr(); lu(5); branch_taken_ex = 1; jump_id = 1;
        expect_o("br_over_lu", C_BR, 2'b00, 2'b00, 0, 2);
        tick(); clr(); jump_id = 1;
        expect_o("jump", C_JMP, 2'b00, 2'b00, 0, 2);
        tick(); lu(5);
        expect_o("lu_over_jump", C_LU, 2'b00, 2'b00, 0, 2);
        tick(); clr();
        expect_o("idle2", C_NRM, 2'b00, 2'b00, 0, 3);

        tick(); dmem_req = 1; branch_taken_ex = 1;
        mem_regwrite = 1; mem_rd = 6; ex_rs = 6;
        expect_o("wait_run", C_FRZ, 2'b10, 2'b00, 0, 3);
        tick(); expect_o("wait_w1", C_FRZ, 2'b10, 2'b00, 0, 4);
        tick(); expect_o("wait_w2", C_FRZ, 2'b10, 2'b00, 0, 5);
        tick(); dmem_ack = 1;
        expect_o("wait_ack", C_BR, 2'b10, 2'b00, 0, 6);
        tick(); clr();
        expect_o("wait_done", C_NRM, 2'b00, 2'b00, 0, 6);
        tick(); dmem_req = 1; dmem_ack = 1;
        expect_o("req_ack_run", C_NRM, 2'b00, 2'b00, 0, 6);

        tick(); dmem_ack = 0;
        expect_o("tmo_run", C_FRZ, 2'b00, 2'b00, 0, 6);
        tick(); expect_o("tmo_w1", C_FRZ, 2'b00, 2'b00, 0, 7);
        tick(); expect_o("tmo_w2", C_FRZ, 2'b00, 2'b00, 0, 8);
        tick(); expect_o("tmo_w3", C_FRZ, 2'b00, 2'b00, 0, 9);
        tick(); expect_o("tmo_w4", C_FRZ, 2'b00, 2'b00, 0, 10);
        tick(); expect_o("tmo_err", C_FRZ, 2'b00, 2'b00, 1, 11);
        tick(); expect_o("tmo_sticky", C_FRZ, 2'b00, 2'b00, 1, 12);
        tick(); reset = 1;
        expect_o("rst_in_wait", C_RST, 2'b00, 2'b00, 0, 0);
        tick(); reset = 0; clr();
        expect_o("rst_to_run", C_NRM, 2'b00, 2'b00, 0, 0);

        for (int i = 0; i < 20; i++) begin
            tick(); lu(5);
            expect_o("sat_lu", C_LU, 2'b00, 2'b00, 0,
                     (i < 15) ? i : 15);
        end
        tick(); clr();
        expect_o("sat_hold", C_NRM, 2'b00, 2'b00, 0, 15);

        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
